breakpoint_csr: RTL and testbench

- Trigger CSR bank (tselect/tdata1/tdata2/tinfo) for a single address-match trigger, RV32 debug-spec mcontrol layout.
- Sits directly upstream of the breakpoint unit and drives its io_bp_0_* configuration inputs.
- Consumes that unit's hit outputs to set the sticky mcontrol.hit bit.
- Accessed by the CSR file via a registered read port and a write port.

---
 rtl/breakpoint_csr_pkg.sv | 69 ++++++
 rtl/breakpoint_csr_if.sv | 33 +++
 rtl/breakpoint_csr_legalize.sv | 38 +++
 rtl/breakpoint_csr.sv | 92 +++++++++
 tb/tb_breakpoint_csr.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/breakpoint_csr_pkg.sv
// Shared constants and types for the single address-match trigger CSR bank
// (tselect/tdata1/tdata2/tinfo, mcontrol layout).
package breakpoint_csr_pkg;

    localparam logic [11:0] CSR_TSELECT = 12'h7A0;
    localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
    localparam logic [11:0] CSR_TDATA2  = 12'h7A2;
    localparam logic [11:0] CSR_TINFO   = 12'h7A4;

    localparam logic [3:0] MCONTROL_TYPE = 4'd2;

    localparam int TYPE_LSB    = 28;
    localparam int DMODE_BIT   = 27;
    localparam int MASKMAX_LSB = 21;
    localparam int HIT_BIT     = 20;
    localparam int ACTION_LSB  = 12;
    localparam int MATCH_LSB   = 7;
    localparam int M_BIT       = 6;
    localparam int S_BIT       = 4;
    localparam int U_BIT       = 3;
    localparam int X_BIT       = 2;
    localparam int W_BIT       = 1;
    localparam int R_BIT       = 0;

    typedef enum logic [1:0] {
        MATCH_EQUAL = 2'd0,
        MATCH_NAPOT = 2'd1,
        MATCH_GE    = 2'd2,
        MATCH_LT    = 2'd3
    } match_e;

    typedef enum logic {
        ACTION_BREAK = 1'b0,
        ACTION_DEBUG = 1'b1
    } action_e;

    typedef struct packed {
        logic    dmode;
        logic    hit;
        action_e action;
        match_e  match;
        logic    m;
        logic    s;
        logic    u;
        logic    x;
        logic    w;
        logic    r;
    } mcontrol_t;

    // Builds the architectural tdata1 read value from the stored fields.
    function automatic logic [31:0] pack_tdata1(mcontrol_t f, logic [5:0] maskmax);
        logic [31:0] word;
        word = '0;
        word[TYPE_LSB +: 4]    = MCONTROL_TYPE;
        word[DMODE_BIT]        = f.dmode;
        word[MASKMAX_LSB +: 6] = maskmax;
        word[HIT_BIT]          = f.hit;
        word[ACTION_LSB]       = f.action;
        word[MATCH_LSB +: 2]   = f.match;
        word[M_BIT]            = f.m;
        word[S_BIT]            = f.s;
        word[U_BIT]            = f.u;
        word[X_BIT]            = f.x;
        word[W_BIT]            = f.w;
        word[R_BIT]            = f.r;
        return word;
    endfunction

endpackage

// File: rtl/breakpoint_csr_if.sv
// CSR-file access port for the trigger bank: write port, registered read port
// and the combinational address-hit indication.
interface breakpoint_csr_if;

    logic [11:0] io_csr_addr;
    logic        io_csr_wen;
    logic [31:0] io_csr_wdata;
    logic        io_csr_ren;
    logic [31:0] io_csr_rdata;
    logic        io_csr_rvalid;
    logic        io_csr_hit;

    modport master (
        output io_csr_addr,
        output io_csr_wen,
        output io_csr_wdata,
        output io_csr_ren,
        input  io_csr_rdata,
        input  io_csr_rvalid,
        input  io_csr_hit
    );

    modport slave (
        input  io_csr_addr,
        input  io_csr_wen,
        input  io_csr_wdata,
        input  io_csr_ren,
        output io_csr_rdata,
        output io_csr_rvalid,
        output io_csr_hit
    );

endinterface

// File: rtl/breakpoint_csr_legalize.sv
// Turns raw tdata1 write data into legal mcontrol fields, and reports whether a
// tdata1/tdata2 write is allowed at all (debug-owned triggers are locked in M-mode).
module bp_tdata1_legalize
    import breakpoint_csr_pkg::*;
(
    input  logic [31:0] wdata,
    input  mcontrol_t   old_fields,
    input  logic        status_debug,
    output logic        write_ok,
    output mcontrol_t   next_fields
);

    logic new_dmode;
    logic unused_wdata;

    assign unused_wdata = ^{wdata[31:28], wdata[26:21], wdata[19:16], wdata[11], wdata[5]};

    always_comb begin
        next_fields = old_fields;
        write_ok    = !(old_fields.dmode && !status_debug);
        new_dmode   = status_debug ? wdata[DMODE_BIT] : old_fields.dmode;

        next_fields.dmode = new_dmode;
        next_fields.hit   = wdata[HIT_BIT];
        // Entering debug mode as an action only makes sense for a debug-owned trigger.
        next_fields.action = (wdata[ACTION_LSB +: 4] == 4'd1 && new_dmode) ? ACTION_DEBUG
                                                                            : ACTION_BREAK;
        next_fields.match  = (wdata[MATCH_LSB +: 4] <= 4'd3) ? match_e'(wdata[MATCH_LSB +: 2])
                                                             : MATCH_EQUAL;
        next_fields.m = wdata[M_BIT];
        next_fields.s = wdata[S_BIT];
        next_fields.u = wdata[U_BIT];
        next_fields.x = wdata[X_BIT];
        next_fields.w = wdata[W_BIT];
        next_fields.r = wdata[R_BIT];
    end

endmodule

// File: rtl/breakpoint_csr.sv
// Trigger CSR bank for one address-match trigger; feeds the breakpoint unit's
// io_bp_0_* configuration and records its hits in the sticky mcontrol.hit bit.
module breakpoint_csr
    import breakpoint_csr_pkg::*;
#(
    parameter int          MASKMAX   = 4,
    parameter logic [31:0] TINFO_VAL = 32'h4
) (
    input  logic               clock,
    input  logic               reset,
    breakpoint_csr_if.slave    csr,
    input  logic               io_status_debug,
    input  logic               io_bp_hit,
    output logic               io_bp_0_control_action,
    output logic [1:0]         io_bp_0_control_tmatch,
    output logic               io_bp_0_control_m,
    output logic               io_bp_0_control_s,
    output logic               io_bp_0_control_u,
    output logic               io_bp_0_control_x,
    output logic               io_bp_0_control_w,
    output logic               io_bp_0_control_r,
    output logic [31:0]        io_bp_0_address
);

    localparam logic [5:0] MASKMAX_FIELD = 6'(MASKMAX);

    mcontrol_t   tdata1_q;
    mcontrol_t   tdata1_next;
    logic [31:0] tdata2_q;
    logic [31:0] read_value;
    logic        write_ok;
    logic        write_tdata1;
    logic        write_tdata2;

    bp_tdata1_legalize u_legalize (
        .wdata        (csr.io_csr_wdata),
        .old_fields   (tdata1_q),
        .status_debug (io_status_debug),
        .write_ok     (write_ok),
        .next_fields  (tdata1_next)
    );

    assign csr.io_csr_hit = (csr.io_csr_addr == CSR_TSELECT) || (csr.io_csr_addr == CSR_TDATA1) ||
                            (csr.io_csr_addr == CSR_TDATA2)  || (csr.io_csr_addr == CSR_TINFO);

    assign write_tdata1 = csr.io_csr_wen && (csr.io_csr_addr == CSR_TDATA1) && write_ok;
    assign write_tdata2 = csr.io_csr_wen && (csr.io_csr_addr == CSR_TDATA2) && write_ok;

    always_comb begin
        read_value = '0;
        case (csr.io_csr_addr)
            CSR_TDATA1: read_value = pack_tdata1(tdata1_q, MASKMAX_FIELD);
            CSR_TDATA2: read_value = tdata2_q;
            CSR_TINFO:  read_value = TINFO_VAL;
            default:    read_value = '0;
        endcase
    end

    // Reads sample the current registers, so a same-cycle write is not yet visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            tdata1_q          <= '0;
            tdata2_q          <= '0;
            csr.io_csr_rdata  <= '0;
            csr.io_csr_rvalid <= 1'b0;
        end else begin
            csr.io_csr_rvalid <= csr.io_csr_ren;
            if (csr.io_csr_ren) begin
                csr.io_csr_rdata <= read_value;
            end
            if (write_tdata1) begin
                tdata1_q <= tdata1_next;
            end else if (io_bp_hit) begin
                tdata1_q.hit <= 1'b1;
            end
            if (write_tdata2) begin
                tdata2_q <= csr.io_csr_wdata;
            end
        end
    end

    assign io_bp_0_control_action = tdata1_q.action;
    assign io_bp_0_control_tmatch = tdata1_q.match;
    assign io_bp_0_control_m      = tdata1_q.m;
    assign io_bp_0_control_s      = tdata1_q.s;
    assign io_bp_0_control_u      = tdata1_q.u;
    assign io_bp_0_control_x      = tdata1_q.x;
    assign io_bp_0_control_w      = tdata1_q.w;
    assign io_bp_0_control_r      = tdata1_q.r;
    assign io_bp_0_address        = tdata2_q;

endmodule

// File: tb/tb_breakpoint_csr.sv
// Bench for breakpoint_csr: directed walk through the main scenarios, then
// random traffic compared against an architectural model of the trigger CSRs.
module tb_breakpoint_csr;

    localparam logic [31:0] TDATA1_RESET = 32'h2080_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        status_debug;
    logic        bp_hit;
    logic        bp_action;
    logic [1:0]  bp_tmatch;
    logic        bp_m, bp_s, bp_u, bp_x, bp_w, bp_r;
    logic [31:0] bp_address;

    int checkCount = 0;
    int failCount  = 0;

    logic [31:0] modelT1;
    logic [31:0] modelT2;
    logic [31:0] modelRdata;
    logic        modelRvalid;

    breakpoint_csr_if bus ();

    breakpoint_csr #(.MASKMAX(4), .TINFO_VAL(32'h4)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .csr                    (bus.slave),
        .io_status_debug        (status_debug),
        .io_bp_hit              (bp_hit),
        .io_bp_0_control_action (bp_action),
        .io_bp_0_control_tmatch (bp_tmatch),
        .io_bp_0_control_m      (bp_m),
        .io_bp_0_control_s      (bp_s),
        .io_bp_0_control_u      (bp_u),
        .io_bp_0_control_x      (bp_x),
        .io_bp_0_control_w      (bp_w),
        .io_bp_0_control_r      (bp_r),
        .io_bp_0_address        (bp_address)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [11:0] addr);
        case (addr)
            12'h7A1: return modelT1;
            12'h7A2: return modelT2;
            12'h7A4: return 32'h4;
            default: return 32'h0;
        endcase
    endfunction

    // Architectural effect of one clock edge with the given inputs.
    task automatic modelStep(input logic rst, input logic [11:0] addr, input logic wen,
                             input logic [31:0] wdata, input logic ren, input logic dbg,
                             input logic hit);
        logic        locked;
        logic        newDmode;
        logic        act;
        logic [3:0]  matchIn;
        logic [31:0] matchStored;
        if (rst) begin
            modelT1     = TDATA1_RESET;
            modelT2     = 32'h0;
            modelRdata  = 32'h0;
            modelRvalid = 1'b0;
        end else begin
            if (ren) modelRdata = modelRead(addr);
            modelRvalid = ren;
            locked   = modelT1[27] && !dbg;
            newDmode = dbg ? wdata[27] : modelT1[27];
            matchIn  = wdata[10:7];
            matchStored = (matchIn < 4'd4) ? 32'(matchIn) : 32'd0;
            act = (wdata[15:12] == 4'd1) && newDmode;
            if (wen && addr == 12'h7A1 && !locked) begin
                modelT1 = TDATA1_RESET | (32'(newDmode) << 27) | (32'(wdata[20]) << 20)
                        | (32'(act) << 12) | (matchStored << 7) | (wdata & 32'h5F);
            end else if (hit) begin
                modelT1 = modelT1 | 32'h0010_0000;
            end
            if (wen && addr == 12'h7A2 && !locked) modelT2 = wdata;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [11:0] addr, input logic wen,
                                 input logic [31:0] wdata, input logic ren, input logic dbg,
                                 input logic hit);
        logic expHit;
        reset            = rst;
        bus.io_csr_addr  = addr;
        bus.io_csr_wen   = wen;
        bus.io_csr_wdata = wdata;
        bus.io_csr_ren   = ren;
        status_debug     = dbg;
        bp_hit           = hit;
        #1;
        expHit = (addr == 12'h7A0) || (addr == 12'h7A1) || (addr == 12'h7A2) || (addr == 12'h7A4);
        checkOutput("csr_hit", 32'(bus.io_csr_hit), 32'(expHit));
        @(posedge clock);
        modelStep(rst, addr, wen, wdata, ren, dbg, hit);
        #1;
        checkOutput("rvalid", 32'(bus.io_csr_rvalid), 32'(modelRvalid));
        checkOutput("rdata", bus.io_csr_rdata, modelRdata);
        checkOutput("bp_control",
                    32'({bp_action, bp_tmatch, bp_m, bp_s, bp_u, bp_x, bp_w, bp_r}),
                    32'({modelT1[12], modelT1[8:7], modelT1[6], modelT1[4:0]}));
        checkOutput("bp_address", bp_address, modelT2);
    endtask

    initial begin
        logic [11:0] addrPool [6];
        logic [11:0] rAddr;
        logic [31:0] rData;
        addrPool = '{12'h7A0, 12'h7A1, 12'h7A2, 12'h7A4, 12'h7A3, 12'h7A1};

        modelT1 = TDATA1_RESET;
        modelT2 = 32'h0;
        modelRdata = 32'h0;
        modelRvalid = 1'b0;

        // Reset, then read tdata1 back.
        @(posedge clock);
        #1;
        applyStimulus(1, 12'h000, 0, 32'h0, 0, 0, 0);
        applyStimulus(1, 12'h000, 0, 32'h0, 1, 0, 0);
        applyStimulus(0, 12'h7A1, 0, 32'h0, 1, 0, 0);
        checkOutput("reset_tdata1", bus.io_csr_rdata, 32'h2080_0000);
        checkOutput("reset_rvalid", 32'(bus.io_csr_rvalid), 32'd1);
        checkOutput("reset_address", bp_address, 32'h0);
        applyStimulus(0, 12'h7A1, 0, 32'h0, 0, 0, 0);
        checkOutput("rvalid_drop", 32'(bus.io_csr_rvalid), 32'd0);

        // Program an execute breakpoint.
        applyStimulus(0, 12'h7A2, 1, 32'h8000_1000, 0, 0, 0);
        applyStimulus(0, 12'h7A1, 1, 32'h0000_005C, 0, 0, 0);
        checkOutput("prog_address", bp_address, 32'h8000_1000);
        checkOutput("prog_control",
                    32'({bp_action, bp_tmatch, bp_m, bp_s, bp_u, bp_x, bp_w, bp_r}), 32'h03C);

        // Illegal match and action in M-mode collapse to 0.
        applyStimulus(0, 12'h7A1, 1, 32'h0000_1280, 0, 0, 0);
        applyStimulus(0, 12'h7A1, 0, 32'h0, 1, 0, 0);
        checkOutput("illegal_legalized", bus.io_csr_rdata, 32'h2080_0000);

        // Debug-owned trigger, then locked against M-mode writes.
        applyStimulus(0, 12'h7A1, 1, 32'h0800_1100, 0, 1, 0);
        applyStimulus(0, 12'h7A2, 1, 32'h0000_1234, 0, 0, 0);
        applyStimulus(0, 12'h7A1, 1, 32'h0000_0000, 0, 0, 0);
        checkOutput("lock_address", bp_address, 32'h8000_1000);
        checkOutput("lock_action", 32'(bp_action), 32'd1);
        checkOutput("lock_tmatch", 32'(bp_tmatch), 32'd2);

        // Sticky hit, and a same-cycle write of hit=0 wins over the hit pulse.
        applyStimulus(0, 12'h000, 0, 32'h0, 0, 0, 1);
        applyStimulus(0, 12'h7A1, 0, 32'h0, 1, 0, 0);
        checkOutput("hit_set", bus.io_csr_rdata, 32'h2890_1100);
        applyStimulus(0, 12'h7A1, 1, 32'h0800_1100, 0, 1, 1);
        applyStimulus(0, 12'h7A1, 0, 32'h0, 1, 1, 0);
        checkOutput("hit_write_wins", bus.io_csr_rdata, 32'h2880_1100);
        applyStimulus(0, 12'h7A1, 1, 32'h0, 1, 1, 0);
        checkOutput("read_before_write", bus.io_csr_rdata, 32'h2880_1100);

        // tselect, tinfo and an unmapped address.
        applyStimulus(0, 12'h7A0, 1, 32'h3, 0, 0, 0);
        applyStimulus(0, 12'h7A0, 0, 32'h0, 1, 0, 0);
        checkOutput("tselect", bus.io_csr_rdata, 32'h0);
        applyStimulus(0, 12'h7A4, 0, 32'h0, 1, 0, 0);
        checkOutput("tinfo", bus.io_csr_rdata, 32'h4);
        applyStimulus(0, 12'h7A3, 0, 32'h0, 1, 0, 0);
        checkOutput("unmapped_rdata", bus.io_csr_rdata, 32'h0);
        checkOutput("unmapped_rvalid", 32'(bus.io_csr_rvalid), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rAddr = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addrPool[$urandom_range(0, 5)];
            rData = $urandom;
            if ($urandom_range(0, 2) == 0) rData[15:12] = 4'd1;
            if ($urandom_range(0, 1) == 0) rData[10:9] = 2'b00;
            applyStimulus($urandom_range(0, 49) == 0, rAddr, 1'($urandom_range(0, 1)), rData,
                          1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 5) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
